// File: rtl/mul32u_seq.sv
// Sequential unsigned shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product,
// one multiplier bit retired per clock, valid/ready on operands and result.
module mul32u_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] prod_hi_o,
  output logic [WIDTH-1:0] prod_lo_o
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d, q_q, q_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH:0]   a_q, a_d, sum;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept, last;

  assign in_ready_o  = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == DONE);
  assign prod_hi_o   = hi_q;
  assign prod_lo_o   = lo_q;
  assign last        = (cnt_q == CW'(WIDTH - 1));

  // A's top bit is always zero after a shift, so adding the full A is the
  // same as adding {1'b0, A[WIDTH-1:0]}.
  assign sum = a_q + (q_q[0] ? {1'b0, m_q} : '0);

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      CALC: begin
        a_d   = {1'b0, sum[WIDTH:1]};
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          cnt_d   = '0;
          hi_d    = sum[WIDTH:1];
          lo_d    = {sum[0], q_q[WIDTH-1:1]};
        end
      end
      DONE: if (out_ready_i) state_d = IDLE;
      default: ;
    endcase
    // Accept is only possible from IDLE or a consuming DONE; it restarts CALC.
    if (accept) begin
      state_d = CALC;
      m_d     = mcand_i;
      q_d     = mplier_i;
      a_d     = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
endmodule

// File: tb/tb_mul32u_seq.sv
// Bench for mul32u_seq: directed vectors with literal expectations plus a
// countdown/arith reference model compared every cycle.
module tb_mul32u_seq;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, in_ready, out_valid;
  logic [31:0] mcand, mplier, prod_hi, prod_lo;
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  mul32u_seq #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .mcand_i(mcand), .mplier_i(mplier), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .prod_hi_o(prod_hi), .prod_lo_o(prod_lo)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: a job takes 32 cycles after accept, then the product a*b is
  // held until consumed; last product stays on the outputs.
  int          m_busy = 0, m_acc_cnt = 0;
  logic        m_valid = 1'b0;
  logic [63:0] m_prod = '0, m_pend = '0;
  logic        m_ready, m_acc;
  assign m_ready = (m_busy == 0) && (!m_valid || out_ready);
  assign m_acc   = in_valid && m_ready;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 0;
      m_valid <= 1'b0;
      m_prod  <= '0;
    end else begin
      if (m_valid && out_ready) m_valid <= 1'b0;
      if (m_acc) begin
        m_busy    <= 32;
        m_pend    <= {32'b0, mcand} * {32'b0, mplier};
        m_acc_cnt <= m_acc_cnt + 1;
      end else if (m_busy > 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_valid <= 1'b1;
          m_prod  <= m_pend;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 64'(in_ready), 64'(m_ready));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("product", {prod_hi, prod_lo}, m_prod);
  end

  // Starts at posedge+1 phase; returns at the negedge where out_valid is seen.
  task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string nm, input bit pulse);
    int  lat;
    bit  ok;
    @(posedge clk); #1;
    in_valid = 1'b1; mcand = a; mplier = b;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin chk({nm, " accept timeout"}, 0, 1); in_valid = 1'b0; return; end
    @(posedge clk); #1;
    in_valid = 1'b0; mcand = $urandom; mplier = $urandom;
    lat = 0; ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
      @(posedge clk); lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'd32);
    chk({nm, " result"}, {prod_hi, prod_lo}, exp);
    if (pulse && ok) begin
      @(negedge clk);
      chk({nm, " pulse"}, 64'(out_valid), 64'd0);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h1 << $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, start;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mcand = '0; mplier = '0;
    #2;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset product", {prod_hi, prod_lo}, 64'd0);
    #10 rst = 1'b0;

    run_one(32'd3, 32'd5, 64'h0000_0000_0000_000F, "3x5", 1);
    run_one(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max x max", 1);
    run_one(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, "msb x 2", 1);
    run_one(32'd0, 32'h1234_5678, 64'd0, "0 x n", 1);
    run_one(32'h1234_5678, 32'd0, 64'd0, "n x 0", 1);

    // Stalled consumer: result and in_ready must hold, in_valid ignored.
    out_ready = 1'b0;
    run_one(32'h1234, 32'h10, 64'h0000_0000_0001_2340, "stall", 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1)); mcand = $urandom; mplier = $urandom;
      @(negedge clk);
      chk("stall valid", 64'(out_valid), 64'd1);
      chk("stall ready", 64'(in_ready), 64'd0);
      chk("stall hold", {prod_hi, prod_lo}, 64'h1_2340);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("after consume valid", 64'(out_valid), 64'd0);
    chk("after consume hold", {prod_hi, prod_lo}, 64'h1_2340);

    // Back-to-back with in_valid held across the consume edge.
    @(posedge clk); #1;
    in_valid = 1'b1; mcand = 32'd7; mplier = 32'd9;
    @(negedge clk);
    chk("b2b first ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    mcand = 32'h1_0000; mplier = 32'h1_0000;
    lat = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk); lat++;
    end
    chk("b2b first latency", 64'(lat), 64'd32);
    chk("b2b first result", {prod_hi, prod_lo}, 64'h3F);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk); lat++;
    end
    chk("b2b second latency", 64'(lat), 64'd32);
    chk("b2b second result", {prod_hi, prod_lo}, 64'h0000_0001_0000_0000);

    // Reset in the middle of a calculation.
    @(posedge clk); #1;
    in_valid = 1'b1; mcand = 32'h1234; mplier = 32'h5678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midcalc rst valid", 64'(out_valid), 64'd0);
    chk("midcalc rst ready", 64'(in_ready), 64'd1);
    chk("midcalc rst product", {prod_hi, prod_lo}, 64'd0);
    #2 rst = 1'b0;
    run_one(32'd6, 32'd7, 64'h2A, "6x7 after rst", 1);

    // Random traffic with random consumer stalls.
    start = m_acc_cnt;
    for (int c = 0; c < 70000 && m_acc_cnt < start + 1000; c++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      mcand = pick(); mplier = pick();
    end
    chk("random accepts", 64'(m_acc_cnt - start), 64'd1000);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
